// File: rtl/mfcc_frame_scheduler_pkg.sv
// Shared definitions for the MFCC frame scheduler: FSM state encoding and status decode helpers.
package mfcc_frame_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_HOP   = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    function automatic logic accepts_samples(input state_e s);
        return (s == ST_PRIME) || (s == ST_HOP);
    endfunction

endpackage

// File: rtl/mfcc_frame_scheduler_timeout_wd.sv
// Stall watchdog: counts cycles while a frame is outstanding, restarts on launch, flags expiry.
module mfcc_frame_scheduler_timeout_wd #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic run_i,
    output logic expire_o
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Expiry deliberately ignores clear_i: launch depends on expiry, so gating here would close a loop.
    assign expire_o = run_i && (cnt_q == W'(TIMEOUT_CYCLES - 1));

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clear_i || !run_i || expire_o) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mfcc_frame_scheduler.sv
// MFCC pipeline sequencer: gates audio into framing, launches overlapping frames, tracks completion,
// counts drops on overrun and aborts stalled frames via the watchdog.
module mfcc_frame_scheduler
    import mfcc_frame_scheduler_pkg::*;
#(
    parameter int FRAME_SIZE     = 256,
    parameter int HOP_SIZE       = 128,
    parameter int NUM_MFCCS      = 13,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             continuous,
    input  logic             clear_err,
    input  logic             audio_valid,
    output logic             audio_ready,
    output logic             pipe_sample_valid,
    output logic             pipe_frame_start,
    input  logic             mfcc_valid,
    output logic             frame_done,
    output logic             busy,
    output logic             overrun,
    output logic             timeout_err,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam int SCNT_W = $clog2(FRAME_SIZE + 1);
    localparam int CCNT_W = $clog2(NUM_MFCCS + 1);

    state_e             state_q;
    logic [SCNT_W-1:0]  sample_cnt_q;
    logic [CCNT_W-1:0]  coef_cnt_q;
    logic               outstanding_q;
    logic               frame_start_q;
    logic               frame_done_q;
    logic               overrun_q;
    logic               timeout_q;
    logic [CNT_W-1:0]   frame_count_q;
    logic [CNT_W-1:0]   drop_count_q;

    logic accept;
    logic coef_last;
    logic wd_expire;
    logic timeout_hit;
    logic frame_clearing;
    logic prime_last;
    logic hop_last;
    logic launch;
    logic drop;

    assign audio_ready       = accepts_samples(state_q);
    assign pipe_sample_valid = audio_valid && audio_ready;
    assign accept            = pipe_sample_valid;

    // A frame that completes on the same cycle the watchdog fires counts as done, not timed out.
    assign coef_last      = outstanding_q && mfcc_valid && (coef_cnt_q == CCNT_W'(NUM_MFCCS - 1));
    assign timeout_hit    = wd_expire && !coef_last;
    assign frame_clearing = coef_last || timeout_hit;

    // Dropping enable takes priority over a sample arriving that cycle.
    assign prime_last = (state_q == ST_PRIME) && enable && accept
                        && (sample_cnt_q == SCNT_W'(FRAME_SIZE - 1));
    assign hop_last   = (state_q == ST_HOP) && enable && accept
                        && (sample_cnt_q == SCNT_W'(HOP_SIZE - 1));

    assign launch = prime_last || (hop_last && (!outstanding_q || frame_clearing));
    assign drop   = hop_last && outstanding_q && !frame_clearing;

    mfcc_frame_scheduler_timeout_wd #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wd (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (launch),
        .run_i    (outstanding_q),
        .expire_o (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sample_cnt_q  <= '0;
            coef_cnt_q    <= '0;
            outstanding_q <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            frame_start_q <= launch;
            frame_done_q  <= coef_last;

            if (launch) begin
                outstanding_q <= 1'b1;
                coef_cnt_q    <= '0;
            end else if (frame_clearing) begin
                outstanding_q <= 1'b0;
                coef_cnt_q    <= '0;
            end else if (outstanding_q && mfcc_valid) begin
                coef_cnt_q <= coef_cnt_q + CCNT_W'(1);
            end

            if (coef_last) frame_count_q <= frame_count_q + CNT_W'(1);
            if (drop)      drop_count_q  <= drop_count_q + CNT_W'(1);

            // New errors outrank a simultaneous clear.
            if (drop)           overrun_q <= 1'b1;
            else if (clear_err) overrun_q <= 1'b0;

            if (timeout_hit)    timeout_q <= 1'b1;
            else if (clear_err) timeout_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q      <= ST_PRIME;
                        sample_cnt_q <= '0;
                    end
                end
                ST_PRIME: begin
                    if (!enable) begin
                        state_q      <= ST_FLUSH;
                        sample_cnt_q <= '0;
                    end else if (prime_last) begin
                        state_q      <= continuous ? ST_HOP : ST_FLUSH;
                        sample_cnt_q <= '0;
                    end else if (accept) begin
                        sample_cnt_q <= sample_cnt_q + SCNT_W'(1);
                    end
                end
                ST_HOP: begin
                    if (!enable) begin
                        state_q      <= ST_FLUSH;
                        sample_cnt_q <= '0;
                    end else if (hop_last) begin
                        sample_cnt_q <= '0;
                    end else if (accept) begin
                        sample_cnt_q <= sample_cnt_q + SCNT_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (!outstanding_q) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pipe_frame_start = frame_start_q;
    assign frame_done       = frame_done_q;
    assign busy             = (state_q != ST_IDLE);
    assign overrun          = overrun_q;
    assign timeout_err      = timeout_q;
    assign frame_count      = frame_count_q;
    assign drop_count       = drop_count_q;

endmodule

// File: tb/tb_mfcc_frame_scheduler.sv
// Directed bench for mfcc_frame_scheduler: per-cycle vector table for prime/stream/overrun/coincident,
// then hand sequences for timeout, error priority, abort, single-frame mode and mid-frame reset.
module tb_mfcc_frame_scheduler;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             enable;
    logic             continuous;
    logic             clear_err;
    logic             audio_valid;
    logic             audio_ready;
    logic             pipe_sample_valid;
    logic             pipe_frame_start;
    logic             mfcc_valid;
    logic             frame_done;
    logic             busy;
    logic             overrun;
    logic             timeout_err;
    logic [CNT_W-1:0] frame_count;
    logic [CNT_W-1:0] drop_count;

    int total = 0;
    int bad   = 0;

    mfcc_frame_scheduler #(
        .FRAME_SIZE     (8),
        .HOP_SIZE       (4),
        .NUM_MFCCS      (3),
        .TIMEOUT_CYCLES (32),
        .CNT_W          (CNT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .continuous        (continuous),
        .clear_err         (clear_err),
        .audio_valid       (audio_valid),
        .audio_ready       (audio_ready),
        .pipe_sample_valid (pipe_sample_valid),
        .pipe_frame_start  (pipe_frame_start),
        .mfcc_valid        (mfcc_valid),
        .frame_done        (frame_done),
        .busy              (busy),
        .overrun           (overrun),
        .timeout_err       (timeout_err),
        .frame_count       (frame_count),
        .drop_count        (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic en, cont, clr, av, mv;
        logic pfs, fd, bsy, rdy, ovr;
        int   fcnt, dcnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic en, cont, clr, av, mv,
                                input logic pfs, fd, bsy, rdy, ovr,
                                input int fcnt, dcnt);
        vec_t v;
        v.en = en; v.cont = cont; v.clr = clr; v.av = av; v.mv = mv;
        v.pfs = pfs; v.fd = fd; v.bsy = bsy; v.rdy = rdy; v.ovr = ovr;
        v.fcnt = fcnt; v.dcnt = dcnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one edge and settle outputs before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int fd_seen;

    initial begin
        rst = 1'b1; enable = 1'b0; continuous = 1'b0; clear_err = 1'b0;
        audio_valid = 1'b0; mfcc_valid = 1'b0;
        tick(); tick();
        check("rst pfs",   pipe_frame_start, 0);
        check("rst fd",    frame_done, 0);
        check("rst busy",  busy, 0);
        check("rst rdy",   audio_ready, 0);
        check("rst psv",   pipe_sample_valid, 0);
        check("rst ovr",   overrun, 0);
        check("rst toe",   timeout_err, 0);
        check("rst fcnt",  frame_count, 0);
        check("rst dcnt",  drop_count, 0);
        rst = 1'b0;

        // Prime: idle->PRIME, then 8 samples; launch visible after the 8th edge.
        tbl.push_back(mk(1,1,0,0,0, 0,0,1,1,0, 0,0));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(1,1,0,1,0, 0,0,1,1,0, 0,0));
        tbl.push_back(mk(1,1,0,1,0, 1,0,1,1,0, 0,0));
        // Stream: each frame completes before its hop finishes.
        for (int f = 1; f <= 3; f++) begin
            tbl.push_back(mk(1,1,0,0,1, 0,0,1,1,0, f-1,0));
            tbl.push_back(mk(1,1,0,0,1, 0,0,1,1,0, f-1,0));
            tbl.push_back(mk(1,1,0,0,1, 0,1,1,1,0, f,0));
            for (int i = 0; i < 3; i++) tbl.push_back(mk(1,1,0,1,0, 0,0,1,1,0, f,0));
            tbl.push_back(mk(1,1,0,1,0, 1,0,1,1,0, f,0));
        end
        // Overrun: hop completes while frame 4 is still outstanding.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1,1,0,1,0, 0,0,1,1,0, 3,0));
        tbl.push_back(mk(1,1,0,1,0, 0,0,1,1,1, 3,1));
        tbl.push_back(mk(1,1,1,0,0, 0,0,1,1,0, 3,1));
        // Coincident: last coefficient lands on the same cycle as the last hop sample.
        tbl.push_back(mk(1,1,0,1,1, 0,0,1,1,0, 3,1));
        tbl.push_back(mk(1,1,0,1,1, 0,0,1,1,0, 3,1));
        tbl.push_back(mk(1,1,0,1,0, 0,0,1,1,0, 3,1));
        tbl.push_back(mk(1,1,0,1,1, 1,1,1,1,0, 4,1));

        foreach (tbl[i]) begin
            enable = tbl[i].en; continuous = tbl[i].cont; clear_err = tbl[i].clr;
            audio_valid = tbl[i].av; mfcc_valid = tbl[i].mv;
            tick();
            check($sformatf("row%0d pfs", i),  pipe_frame_start, tbl[i].pfs);
            check($sformatf("row%0d fd", i),   frame_done, tbl[i].fd);
            check($sformatf("row%0d busy", i), busy, tbl[i].bsy);
            check($sformatf("row%0d rdy", i),  audio_ready, tbl[i].rdy);
            check($sformatf("row%0d ovr", i),  overrun, tbl[i].ovr);
            check($sformatf("row%0d fcnt", i), frame_count, tbl[i].fcnt);
            check($sformatf("row%0d dcnt", i), drop_count, tbl[i].dcnt);
        end

        // Timeout: frame launched on the last table row never gets coefficients.
        clear_err = 1'b0; audio_valid = 1'b0; mfcc_valid = 1'b0;
        fd_seen = 0;
        repeat (31) begin
            tick();
            if (frame_done) fd_seen++;
        end
        check("to_before_expiry", timeout_err, 0);
        tick();
        check("to_set",     timeout_err, 1);
        check("to_fcnt",    frame_count, 4);
        check("to_no_done", fd_seen, 0);
        audio_valid = 1'b1;
        repeat (3) tick();
        check("to_hop_partial", pipe_frame_start, 0);
        tick();
        check("to_relaunch", pipe_frame_start, 1);
        audio_valid = 1'b0; clear_err = 1'b1;
        tick();
        check("to_clear", timeout_err, 0);
        clear_err = 1'b0;

        // Overrun raised on the same cycle as clear_err: the error must stick.
        audio_valid = 1'b1;
        repeat (3) tick();
        clear_err = 1'b1;
        tick();
        check("ovr_beats_clr", overrun, 1);
        check("ovr_dcnt2",     drop_count, 2);
        check("ovr_no_launch", pipe_frame_start, 0);
        clear_err = 1'b0;

        // Abort: enable drops mid-hop; FLUSH until the outstanding frame completes.
        tick(); tick();
        enable = 1'b0;
        tick();
        check("abort_rdy",  audio_ready, 0);
        check("abort_busy", busy, 1);
        check("abort_psv",  pipe_sample_valid, 0);
        audio_valid = 1'b0; mfcc_valid = 1'b1;
        tick(); tick();
        check("abort_fd_early", frame_done, 0);
        tick();
        check("abort_fd",   frame_done, 1);
        check("abort_fcnt", frame_count, 5);
        check("abort_busy_flush", busy, 1);
        mfcc_valid = 1'b0;
        tick();
        check("abort_idle", busy, 0);

        // Single-frame mode: one prime frame, then FLUSH and back to IDLE.
        enable = 1'b1; continuous = 1'b0;
        tick();
        check("single_prime_rdy", audio_ready, 1);
        audio_valid = 1'b1;
        repeat (7) tick();
        check("single_pfs_early", pipe_frame_start, 0);
        tick();
        check("single_pfs",   pipe_frame_start, 1);
        check("single_flush", audio_ready, 0);
        check("single_busy",  busy, 1);
        audio_valid = 1'b0; enable = 1'b0; mfcc_valid = 1'b1;
        repeat (3) tick();
        check("single_fd",   frame_done, 1);
        check("single_fcnt", frame_count, 6);
        mfcc_valid = 1'b0;
        tick();
        check("single_idle", busy, 0);

        // Reset mid-frame aborts everything; stray coefficients afterwards are ignored.
        enable = 1'b1; continuous = 1'b1;
        tick();
        audio_valid = 1'b1;
        repeat (8) tick();
        check("rst_pre_launch", pipe_frame_start, 1);
        audio_valid = 1'b0; mfcc_valid = 1'b1;
        tick();
        rst = 1'b1; enable = 1'b0; mfcc_valid = 1'b0;
        tick();
        check("midrst pfs",  pipe_frame_start, 0);
        check("midrst fd",   frame_done, 0);
        check("midrst busy", busy, 0);
        check("midrst rdy",  audio_ready, 0);
        check("midrst ovr",  overrun, 0);
        check("midrst toe",  timeout_err, 0);
        check("midrst fcnt", frame_count, 0);
        check("midrst dcnt", drop_count, 0);
        rst = 1'b0; mfcc_valid = 1'b1;
        fd_seen = 0;
        repeat (3) begin
            tick();
            if (frame_done) fd_seen++;
        end
        mfcc_valid = 1'b0;
        check("postrst_no_done", fd_seen, 0);
        check("postrst_fcnt",    frame_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
